// File: rtl/iot_event_arbiter.sv
// Buffers one on/off event per device and forwards one per cycle to the monitor by round-robin.
// Optional IOT_ARB_DEDUP_EN: drop accepted events that match the device's current dev_state.
module iot_event_arbiter #(
  parameter int N_DEV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] ev_valid,
  input  logic [N_DEV-1:0] ev_on,
  output logic [N_DEV-1:0] ev_ready,
  output logic             change,
  output logic             on_off,
  output logic [N_DEV-1:0] grant,
  output logic [N_DEV-1:0] dev_state,
  output logic             busy
);

  localparam int          PTR_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  localparam int unsigned N_U   = N_DEV;

  logic [N_DEV-1:0] r_pend_v;
  logic [N_DEV-1:0] r_pend_on;
  logic [PTR_W-1:0] r_ptr;
  logic             r_change;
  logic             r_on_off;
  logic [N_DEV-1:0] r_grant;
  logic [N_DEV-1:0] r_dev_state;

  logic [N_DEV-1:0] w_accept;
  logic [N_DEV-1:0] w_load;
  logic [N_DEV-1:0] w_gnt_oh;
  logic [PTR_W-1:0] w_sel;
  logic             w_found;

  assign w_accept = ev_valid & ~r_pend_v;

`ifdef IOT_ARB_DEDUP_EN
  assign w_load = w_accept & (ev_on ^ r_dev_state);
`else
  assign w_load = w_accept;
`endif

  // Search starts one past the last winner, so the previous grantee ranks last.
  always_comb begin
    int unsigned idx;
    w_found = 1'b0;
    w_sel   = r_ptr;
    idx     = 0;
    for (int unsigned k = 1; k <= N_U; k++) begin
      idx = (32'(r_ptr) + k) % N_U;
      if (!w_found && r_pend_v[PTR_W'(idx)]) begin
        w_found = 1'b1;
        w_sel   = PTR_W'(idx);
      end
    end
  end

  assign w_gnt_oh = w_found ? (N_DEV'(1) << w_sel) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_v    <= '0;
      r_pend_on   <= '0;
      r_ptr       <= PTR_W'(N_DEV - 1);
      r_change    <= 1'b0;
      r_on_off    <= 1'b0;
      r_grant     <= '0;
      r_dev_state <= '0;
    end else begin
      // A granted slot is never loaded on the same edge: its ev_ready was low.
      r_pend_v  <= (r_pend_v & ~w_gnt_oh) | w_load;
      r_pend_on <= (r_pend_on & ~w_load) | (ev_on & w_load);
      if (w_found) begin
        r_change           <= 1'b1;
        r_on_off           <= r_pend_on[w_sel];
        r_grant            <= w_gnt_oh;
        r_dev_state[w_sel] <= r_pend_on[w_sel];
        r_ptr              <= w_sel;
      end else begin
        r_change <= 1'b0;
        r_on_off <= 1'b0;
        r_grant  <= '0;
      end
    end
  end

  assign ev_ready  = ~r_pend_v;
  assign change    = r_change;
  assign on_off    = r_on_off;
  assign grant     = r_grant;
  assign dev_state = r_dev_state;
  assign busy      = |r_pend_v;

endmodule
